// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 16x oversampled, LSB first.
// Frame: start bit, NB_DATA data bits, NB_STOP stop bits. Each good byte
// is delivered on o_rx_data with a one-cycle o_rx_done strobe.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after
// the data bits and an o_parity_error strobe.
module uart_rx #(
    parameter int NB_DATA         = 8,
    parameter int NB_STOP         = 1,
    parameter int BAUD_RATE       = 9600,
    parameter int SYS_CLOCK       = 100000000,
    parameter int TICK_RATE       = SYS_CLOCK / (BAUD_RATE * 16),
    parameter int NB_TICK_COUNTER = $clog2(TICK_RATE),
    parameter int NB_DATA_COUNTER = $clog2(NB_DATA)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_data,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_done,
    output logic               o_frame_error,
`ifdef UART_RX_PARITY_EN
    output logic               o_parity_error,
`endif
    output logic               o_busy
);

    // Counter widths never collapse to zero; n_cnt also indexes stop bits.
    localparam int TW  = (NB_TICK_COUNTER > 0) ? NB_TICK_COUNTER : 1;
    localparam int SW  = (NB_STOP > 1) ? $clog2(NB_STOP) : 1;
    localparam int DW  = (NB_DATA_COUNTER > 0) ? NB_DATA_COUNTER : 1;
    localparam int NW  = (DW > SW) ? DW : SW;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_RATE - 1);
    localparam logic [NW-1:0] DATA_LAST = NW'(NB_DATA - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(NB_STOP - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    logic               rx_meta;
    logic               rx_s;
    logic [TW-1:0]      tick_cnt;
    logic               tick;
    state_t             state, state_n;
    logic [3:0]         s_cnt, s_cnt_n;
    logic [NW-1:0]      n_cnt, n_cnt_n;
    logic [NB_DATA-1:0] shreg, shreg_n;
    logic               frame_ok;
    logic               done_n;
    logic               ferr_n;
`ifdef UART_RX_PARITY_EN
    logic               par_bit, par_bit_n;
    logic               perr_n;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign frame_ok = ~(^shreg ^ par_bit);
`else
    assign frame_ok = 1'b1;
`endif

    // Two-flop synchronizer, reset to the idle-high line level.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx_data;
            rx_s    <= rx_meta;
        end
    end

    // Free-running divider producing one tick per oversample period.
    always_ff @(posedge i_clock) begin
        if (i_reset || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick   = (tick_cnt == TICK_LAST);
    assign o_busy = (state != IDLE);

    // FSM state and per-frame datapath registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
            s_cnt <= '0;
            n_cnt <= '0;
            shreg <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state <= state_n;
            s_cnt <= s_cnt_n;
            n_cnt <= n_cnt_n;
            shreg <= shreg_n;
`ifdef UART_RX_PARITY_EN
            par_bit <= par_bit_n;
`endif
        end
    end

    // Next-state logic: samples are taken on ticks at mid-bit positions.
    always_comb begin
        state_n = state;
        s_cnt_n = s_cnt;
        n_cnt_n = n_cnt;
        shreg_n = shreg;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n = par_bit;
        perr_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    s_cnt_n = '0;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt == 4'd7) begin
                        if (!rx_s) begin
                            s_cnt_n = '0;
                            n_cnt_n = '0;
                            state_n = DATA;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt == 4'd15) begin
                        shreg_n = {rx_s, shreg[NB_DATA-1:1]};
                        s_cnt_n = '0;
                        if (n_cnt == DATA_LAST) begin
                            n_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            n_cnt_n = n_cnt + 1'b1;
                        end
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_cnt == 4'd15) begin
                        par_bit_n = rx_s;
                        s_cnt_n   = '0;
                        state_n   = STOP;
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_cnt == 4'd15) begin
                        s_cnt_n = '0;
                        if (n_cnt == STOP_LAST) begin
                            n_cnt_n = '0;
                            if (rx_s) begin
                                state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                                perr_n  = ~frame_ok;
`endif
                                done_n  = frame_ok;
                            end else begin
                                ferr_n  = 1'b1;
                                state_n = BREAK;
                            end
                        end else begin
                            n_cnt_n = n_cnt + 1'b1;
                        end
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Registered outputs: byte held between good frames, strobes one cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_rx_data     <= '0;
            o_rx_done     <= 1'b0;
            o_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_error <= 1'b0;
`endif
        end else begin
            if (done_n) begin
                o_rx_data <= shreg;
            end
            o_rx_done     <= done_n;
            o_frame_error <= ferr_n;
`ifdef UART_RX_PARITY_EN
            o_parity_error <= perr_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int SYS_CLOCK = 1600000;
    localparam int BAUD_RATE = 10000;
    localparam int NB_DATA   = 8;
    localparam int BIT_CYC   = SYS_CLOCK / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS  = 1;
`else
    localparam int PAR_BITS  = 0;
`endif
    // Done is expected half a bit into the stop bit, measured from the start edge.
    localparam int LAT_NOM   = (2 * (1 + NB_DATA + PAR_BITS) + 1) * BIT_CYC / 2;

    localparam int R_DONE = 0;
    localparam int R_FERR = 1;
    localparam int R_PERR = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    always #5 clk = ~clk;

    logic [NB_DATA-1:0] rx_data;
    logic               rx_done;
    logic               ferr;
    logic               busy;
`ifdef UART_RX_PARITY_EN
    logic               perr;
`endif

    uart_rx #(
        .SYS_CLOCK(SYS_CLOCK),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_rx_data     (rx),
        .o_rx_data     (rx_data),
        .o_rx_done     (rx_done),
        .o_frame_error (ferr),
`ifdef UART_RX_PARITY_EN
        .o_parity_error(perr),
`endif
        .o_busy        (busy)
    );

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [NB_DATA-1:0] exp_q[$];
    logic [NB_DATA-1:0] exp_data = '0;
    int exp_done = 0;
    int exp_ferr = 0;
    int exp_perr = 0;

    int done_cnt = 0;
    int done_hi  = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int unsigned done_cyc = 0;
    int unsigned busy_rise_cyc = 0;
    int unsigned busy_fall_cyc = 0;
    logic prev_done = 1'b0;
    logic prev_ferr = 1'b0;
    logic prev_perr = 1'b0;
    logic prev_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: outcome of one frame from its bits alone.
    function automatic int frame_result(input logic [NB_DATA-1:0] b, input logic par_v,
                                        input logic stop_v);
        if (!stop_v) return R_FERR;
        if (PAR_BITS != 0 && (($countones(b) + int'(par_v)) % 2) != 0) return R_PERR;
        return R_DONE;
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic cur_perr;
`ifdef UART_RX_PARITY_EN
        cur_perr = perr;
`else
        cur_perr = 1'b0;
`endif
        if (rx_done) begin
            done_hi++;
            done_cyc = cyc;
            if (!prev_done) done_cnt++;
            chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("rx_byte", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        if (ferr && !prev_ferr) ferr_cnt++;
        if (cur_perr && !prev_perr) perr_cnt++;
        if (rx_done || ferr) chk("done_ferr_excl", 32'(rx_done & ferr), 32'd0);
        if (busy && !prev_busy) busy_rise_cyc = cyc;
        if (!busy && prev_busy) busy_fall_cyc = cyc;
        prev_done = rx_done;
        prev_ferr = ferr;
        prev_perr = cur_perr;
        prev_busy = busy;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [NB_DATA-1:0] b, input logic par_v, input logic stop_v);
        int r;
        r = frame_result(b, par_v, stop_v);
        if (r == R_DONE) begin
            exp_q.push_back(b);
            exp_done++;
            exp_data = b;
        end else if (r == R_FERR) begin
            exp_ferr++;
        end else begin
            exp_perr++;
        end
        drive_bit(1'b0);
        for (int i = 0; i < NB_DATA; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_v);
`endif
        drive_bit(stop_v);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int unsigned start_cyc;
        int unsigned g_start;
        int lat;
        logic [NB_DATA-1:0] b;
        logic stop_v;
        logic par_v;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        chk("reset_data", 32'(rx_data), 32'd0);
        chk("reset_done", 32'(rx_done), 32'd0);
        chk("reset_ferr", 32'(ferr), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        idle_cycles(50);

        // Single good frame 0xA5: count, latency and busy window.
        start_cyc = cyc;
        send_frame(8'hA5, ^8'hA5, 1'b1);
        idle_cycles(BIT_CYC);
        lat = int'(done_cyc - start_cyc);
        chk("a5_done_cnt", 32'(done_cnt), 32'(exp_done));
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_latency", 32'(lat >= LAT_NOM - 10 && lat <= LAT_NOM + 10), 32'd1);
        chk("a5_busy_rise", 32'(busy_rise_cyc - start_cyc >= 2 && busy_rise_cyc - start_cyc <= 4), 32'd1);
        chk("a5_busy_fall", busy_fall_cyc, done_cyc);

        // Back-to-back 0x00 then 0xFF, no idle gap.
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle_cycles(BIT_CYC);
        chk("b2b_done_cnt", 32'(done_cnt), 32'(exp_done));
        chk("b2b_ferr_cnt", 32'(ferr_cnt), 32'(exp_ferr));
        chk("b2b_data", 32'(rx_data), 32'hFF);

        // 40-cycle low glitch on an idle line.
        g_start = cyc;
        rx = 1'b0;
        repeat (40) @(negedge clk);
        idle_cycles(3 * BIT_CYC);
        chk("glitch_entered", 32'(busy_rise_cyc > g_start), 32'd1);
        chk("glitch_idle", 32'(busy), 32'd0);
        chk("glitch_done_cnt", 32'(done_cnt), 32'(exp_done));
        chk("glitch_ferr_cnt", 32'(ferr_cnt), 32'(exp_ferr));
        chk("glitch_data", 32'(rx_data), 32'(exp_data));

        // 0x3C with a low stop bit, line held low 3 bits, then 0x5A.
        send_frame(8'h3C, ^8'h3C, 1'b0);
        rx = 1'b0;
        repeat (3 * BIT_CYC) @(negedge clk);
        chk("ferr_cnt", 32'(ferr_cnt), 32'(exp_ferr));
        chk("ferr_data_hold", 32'(rx_data), 32'(exp_data));
        chk("ferr_break_busy", 32'(busy), 32'd1);
        chk("ferr_no_done", 32'(done_cnt), 32'(exp_done));
        idle_cycles(BIT_CYC);
        chk("break_exit", 32'(busy), 32'd0);
        send_frame(8'h5A, ^8'h5A, 1'b1);
        idle_cycles(BIT_CYC);
        chk("after_break_done", 32'(done_cnt), 32'(exp_done));
        chk("after_break_data", 32'(rx_data), 32'h5A);

        // Reset during data bit 4 of 0x81, then a full 0x7E.
        b = 8'h81;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        repeat (BIT_CYC / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        exp_data = '0;
        chk("midreset_data", 32'(rx_data), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        idle_cycles(12 * BIT_CYC);
        chk("midreset_no_done", 32'(done_cnt), 32'(exp_done));
        chk("midreset_no_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        chk("midreset_data_hold", 32'(rx_data), 32'd0);
        send_frame(8'h7E, ^8'h7E, 1'b1);
        idle_cycles(BIT_CYC);
        chk("post_reset_done", 32'(done_cnt), 32'(exp_done));
        chk("post_reset_data", 32'(rx_data), 32'h7E);

        // Random frames with random gaps, occasional bad stop (and parity).
        for (int k = 0; k < 10; k++) begin
            b      = NB_DATA'($urandom_range(0, 255));
            stop_v = ($urandom_range(0, 5) != 0);
            par_v  = ^b;
`ifdef UART_RX_PARITY_EN
            if ($urandom_range(0, 4) == 0) par_v = ~par_v;
`endif
            send_frame(b, par_v, stop_v);
            if (!stop_v) idle_cycles(BIT_CYC);
            idle_cycles($urandom_range(0, 2) * BIT_CYC + $urandom_range(0, 15));
        end
        idle_cycles(BIT_CYC);
        chk("rand_done_cnt", 32'(done_cnt), 32'(exp_done));
        chk("rand_ferr_cnt", 32'(ferr_cnt), 32'(exp_ferr));
        chk("rand_data", 32'(rx_data), 32'(exp_data));

`ifdef UART_RX_PARITY_EN
        // 0x07 with wrong parity (0), then with correct parity (1).
        send_frame(8'h07, 1'b0, 1'b1);
        idle_cycles(BIT_CYC);
        chk("par_bad_perr", 32'(perr_cnt), 32'(exp_perr));
        chk("par_bad_no_done", 32'(done_cnt), 32'(exp_done));
        chk("par_bad_data_hold", 32'(rx_data), 32'(exp_data));
        send_frame(8'h07, 1'b1, 1'b1);
        idle_cycles(BIT_CYC);
        chk("par_good_done", 32'(done_cnt), 32'(exp_done));
        chk("par_good_data", 32'(rx_data), 32'h07);
        chk("par_good_perr", 32'(perr_cnt), 32'(exp_perr));
`endif

        // ---------------- final report ----------------
        chk("done_width", 32'(done_hi), 32'(done_cnt));
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver counterpart of the existing UART transmitter.
- Accepts an 8N1-style asynchronous serial stream on the board RX pin, oversamples it 16x and delivers each received byte with a one-cycle strobe.
- Sits beside the uart_toplevel TX path in toplevel.
- Intended to feed BIP program loading and debug commands from the host.

Parameters:
- NB_DATA, 8, data bits per frame, sent LSB first.
- NB_STOP, 1, stop bits per frame.
- BAUD_RATE, 9600, line bit rate.
- SYS_CLOCK, 100000000, i_clock frequency in Hz.
- TICK_RATE, SYS_CLOCK/(BAUD_RATE*16), i_clock cycles per oversample tick.
- NB_TICK_COUNTER, $clog2(TICK_RATE), tick counter width.
- NB_DATA_COUNTER, $clog2(NB_DATA), bit index counter width.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset; clock i_clock.
- i_rx_data  in  1  asynchronous serial line, idle high.
- o_rx_data  out  NB_DATA  last correctly framed byte; held until the next good frame.
- o_rx_done  out  1  one-cycle pulse when o_rx_data is updated.
- o_frame_error  out  1  one-cycle pulse when a stop bit is sampled low.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Input sync: i_rx_data passes through a 2-FF synchronizer; both FFs reset to 1. All logic uses the synced bit rx_s.
- Tick generator: free-running counter 0..TICK_RATE-1. Tick is a one-cycle pulse when the counter equals TICK_RATE-1; the counter then wraps to 0. Counter resets to 0.
- Per-frame counters:
  - s_cnt: 4-bit oversample counter, advances on ticks only.
  - n_cnt: NB_DATA_COUNTER-bit data-bit index.
  - shift register: NB_DATA bits, shifts right with the new bit entering at the MSB, so the byte is LSB first.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s==0, clear s_cnt and go to START (no tick needed).
  - START: on tick with s_cnt==7 (mid start bit):
    - rx_s==0: clear s_cnt and n_cnt, go to DATA.
    - rx_s==1: glitch; return to IDLE with no output pulse.
  - DATA: on tick with s_cnt==15:
    - shift in rx_s and clear s_cnt.
    - if n_cnt==NB_DATA-1, go to STOP; else increment n_cnt.
  - STOP: on tick with s_cnt==15, or s_cnt==15 of the last stop bit when NB_STOP>1:
    - rx_s==1: load o_rx_data from the shift register, pulse o_rx_done the next cycle, go to IDLE.
    - rx_s==0: pulse o_frame_error the next cycle, leave o_rx_data unchanged, go to BREAK.
  - BREAK: stay until rx_s==1, then go to IDLE. This prevents a held-low line from re-triggering frames.
- Latency: o_rx_done asserts exactly 1 cycle after the mid-stop-bit tick, about 9.5 bit times after the start edge.
- o_rx_done and o_frame_error are never high in the same cycle.
- Reset values, including reset mid-frame: state IDLE; o_rx_data=0; o_rx_done=0; o_frame_error=0; o_busy=0; counters 0. A partial frame is discarded.
- Back-to-back frames: a start edge arriving in the first cycle after STOP is accepted with no dead time.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP; the parity bit is sampled at s_cnt==15.
  - Even parity: the XOR of the data bits and the parity bit must be 0.
  - Adds output o_parity_error (1 bit, reset 0). It pulses in the same cycle the frame would report done.
  - On parity mismatch with a good stop bit: o_parity_error pulses, o_rx_done does not pulse, o_rx_data is unchanged.
- Not defined: no PARITY state, no o_parity_error port; the frame is NB_DATA bits plus stop.

Test Plan:
- Bench overrides: SYS_CLOCK=1600000, BAUD_RATE=10000, giving TICK_RATE=10 and 160 cycles per bit.
- Send 0xA5 framed correctly:
  - o_rx_done pulses once, 1 cycle wide, with o_rx_data=0xA5.
  - o_busy is high from the start edge until the done pulse.
- Send 0x00 then 0xFF back to back, with no idle gap:
  - two o_rx_done pulses, carrying 0x00 then 0xFF.
  - no o_frame_error.
- Low glitch of 40 cycles on an idle line:
  - FSM returns to IDLE.
  - no o_rx_done or o_frame_error; o_rx_data unchanged.
- Send 0x3C with the stop bit forced low, keep the line low for 3 bit times, then send 0x5A:
  - one o_frame_error pulse.
  - o_rx_data stays at its previous value until 0x5A is received; then o_rx_done pulses with 0x5A.
- Assert i_reset during data bit 4 of 0x81, then send a full 0x7E:
  - after reset, o_rx_data=0 and there is no pulse for the aborted frame.
  - 0x7E is then received correctly.
- With UART_RX_PARITY_EN defined, send 0x07 with a wrong parity bit (0), then 0x07 with correct parity (1):
  - first frame: o_parity_error pulses, no o_rx_done.
  - second frame: o_rx_done pulses with o_rx_data=0x07.
